// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared vote-mode encodings and vote-count reduction for the UART RX sampler
//
// Contents:
//   VOTE_1/VOTE_3/VOTE_5 : vote_mode encodings (2'b11 is reserved and behaves as VOTE_3)
//   MAX_VOTES_DEF        : default largest vote count
//   eff_votes()          : vote count actually usable for a given prescale and mode
package uart_rx_pkg;

    localparam logic [1:0] VOTE_1 = 2'b00;
    localparam logic [1:0] VOTE_3 = 2'b01;
    localparam logic [1:0] VOTE_5 = 2'b10;

    localparam int MAX_VOTES_DEF = 5;

    // The window ends at the bit midpoint c = prescale>>1 and needs N-1 edges
    // before it, so N is cut to the largest odd value that still fits (<= c+1).
    function automatic logic [2:0] eff_votes(input logic [15:0] prescale,
                                             input logic [1:0]  mode);
        logic [2:0]  req;
        logic [15:0] c;
        logic [15:0] lim;
        case (mode)
            VOTE_1:  req = 3'd1;
            VOTE_5:  req = 3'd5;
            default: req = 3'd3;
        endcase
        c   = prescale >> 1;
        lim = c[0] ? c : c + 16'd1;
        if (c < 16'(req) - 16'd1)
            return lim[2:0];
        return req;
    endfunction

endpackage

// File: rtl/rx_majority_vote.sv
// rtl/rx_majority_vote.sv - combinational majority and unanimity over the lowest n votes
//
// Ports:
//   votes_i     : vote vector, bit 0 is the newest vote
//   n_i         : number of valid votes (odd, 1..MAX_VOTES)
//   maj_o       : 1 when at least (n+1)/2 of the valid votes are 1
//   unanimous_o : 1 when all valid votes are equal
module rx_majority_vote #(
    parameter int MAX_VOTES = 5
) (
    input  logic [MAX_VOTES-1:0] votes_i,
    input  logic [2:0]           n_i,
    output logic                 maj_o,
    output logic                 unanimous_o
);

    logic [2:0] pop;
    logic       all_ones;
    logic       all_zeros;

    always_comb begin
        pop       = 3'd0;
        all_ones  = 1'b1;
        all_zeros = 1'b1;
        for (int i = 0; i < MAX_VOTES; i++) begin
            if (3'(i) < n_i) begin
                pop       = pop + 3'(votes_i[i]);
                all_ones  = all_ones & votes_i[i];
                all_zeros = all_zeros & ~votes_i[i];
            end
        end
        // Threshold computed at 4 bits so n=7 does not wrap.
        maj_o       = ({1'b0, pop} >= (({1'b0, n_i} + 4'd1) >> 1));
        unanimous_o = all_ones | all_zeros;
    end

endmodule

// File: rtl/rx_multi_vote_sampler.sv
// rtl/rx_multi_vote_sampler.sv - majority-voted UART RX bit sampler centred on the bit midpoint
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   rx_in        : synchronised serial input
//   samp_en      : sampling enable from the RX FSM
//   prescale     : edges per bit
//   edge_cnt     : edge position within the current bit
//   vote_mode    : 00=1, 01=3, 10=5 votes, 11 behaves as 01
//   sampled_bit  : majority-voted bit (registered)
//   sample_valid : one-cycle strobe with each new decision
//   noise_flag   : last decision had disagreeing or missing votes
module rx_multi_vote_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int CNT_W      = 6,
    parameter int MAX_VOTES  = MAX_VOTES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  samp_en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [CNT_W-1:0]      edge_cnt,
    input  logic [1:0]            vote_mode,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  noise_flag
);

    localparam int VD = (MAX_VOTES > 1) ? MAX_VOTES - 1 : 1;
    localparam int SW = CNT_W + 1;

    logic [PRESCALE_W-1:0] shadow_pres_q, shadow_pres_d;
    logic [2:0]            shadow_n_q, shadow_n_d;
    logic [VD-1:0]         vote_q, vote_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  bit_q, bit_d;
    logic                  valid_q, valid_d;
    logic                  noise_q, noise_d;

    logic                  load;
    logic [2:0]            n_req, n_load, n_cur;
    logic [PRESCALE_W-1:0] pres_cur;
    logic signed [SW-1:0]  c_s, lo_s, e_s;
    logic                  in_range, at_dec, capture;
    logic                  maj, unanimous;

    // The first edge of a bit uses the incoming prescale/mode directly, so a
    // window that starts at edge 0 (small prescale) already sees the new bit.
    assign load     = samp_en && (edge_cnt == '0);
    assign n_req    = eff_votes(16'(prescale), vote_mode);
    assign n_load   = (n_req > 3'(MAX_VOTES)) ? 3'(MAX_VOTES) : n_req;
    assign n_cur    = load ? n_load : shadow_n_q;
    assign pres_cur = load ? prescale : shadow_pres_q;

    assign c_s      = signed'(SW'(pres_cur >> 1));
    assign lo_s     = c_s - signed'(SW'(n_cur)) + signed'(SW'(1));
    assign e_s      = signed'({1'b0, edge_cnt});
    assign in_range = (edge_cnt < CNT_W'(pres_cur));
    assign at_dec   = in_range && (e_s == c_s);
    assign capture  = in_range && (e_s >= lo_s) && (e_s < c_s);

    rx_majority_vote #(.MAX_VOTES(MAX_VOTES)) u_vote (
        .votes_i     (MAX_VOTES'({vote_q, rx_in})),
        .n_i         (n_cur),
        .maj_o       (maj),
        .unanimous_o (unanimous)
    );

    always_comb begin
        shadow_pres_d = shadow_pres_q;
        shadow_n_d    = shadow_n_q;
        vote_d        = vote_q;
        cnt_d         = cnt_q;
        bit_d         = bit_q;
        valid_d       = 1'b0;
        noise_d       = noise_q;
        if (!samp_en) begin
            vote_d  = '1;
            cnt_d   = 3'd0;
            bit_d   = 1'b1;
            noise_d = 1'b0;
        end else begin
            if (load) begin
                shadow_pres_d = prescale;
                shadow_n_d    = n_load;
            end
            if (at_dec) begin
                // Uncaptured votes stay at idle 1s; a short window is always noisy.
                bit_d   = maj;
                noise_d = !unanimous || (cnt_q != n_cur - 3'd1);
                valid_d = 1'b1;
                vote_d  = '1;
                cnt_d   = 3'd0;
            end else if (capture) begin
                vote_d = (vote_q << 1) | VD'(rx_in);
                if (cnt_q != 3'd7)
                    cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_pres_q <= '0;
            shadow_n_q    <= 3'd1;
            vote_q        <= '1;
            cnt_q         <= 3'd0;
            bit_q         <= 1'b1;
            valid_q       <= 1'b0;
            noise_q       <= 1'b0;
        end else begin
            shadow_pres_q <= shadow_pres_d;
            shadow_n_q    <= shadow_n_d;
            vote_q        <= vote_d;
            cnt_q         <= cnt_d;
            bit_q         <= bit_d;
            valid_q       <= valid_d;
            noise_q       <= noise_d;
        end
    end

    assign sampled_bit  = bit_q;
    assign sample_valid = valid_q;
    assign noise_flag   = noise_q;

endmodule

// File: doc/rx_multi_vote_sampler.md
Name: rx_multi_vote_sampler

Overview:
- Parametrised next-generation UART RX bit sampler.
- Takes N in {1,3,5} oversampled votes of rx_in, centred on the bit midpoint, and issues a majority-voted bit.
- Also issues a one-cycle valid strobe and a noise flag when the votes are not unanimous.
- Sits between the RX edge/bit counter and the RX FSM/deserializer; edge_cnt is supplied by the existing edge counter.

Parameters:
- PRESCALE_W, 6, width of the prescale input (oversampling ratio up to 2^PRESCALE_W-1).
- CNT_W, 6, width of edge_cnt; must be ≥ PRESCALE_W.
- MAX_VOTES, 5, largest supported vote count; must be odd, 1..7. Shift register depth is MAX_VOTES-1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rx_in  in  1  synchronised serial input
- samp_en  in  1  sampling enable from RX FSM
- prescale  in  PRESCALE_W  oversampling ratio (edges per bit)
- edge_cnt  in  CNT_W  edge position within current bit, 0..prescale-1
- vote_mode  in  2  00=1 vote, 01=3 votes, 10=5 votes, 11=reserved (treated as 3)
- sampled_bit  out  1  majority-voted bit
- sample_valid  out  1  one-cycle strobe, new sampled_bit
- noise_flag  out  1  votes of last decision not unanimous

Behaviour:
- Reset (async, rst=1): sampled_bit=1, sample_valid=0, noise_flag=0, vote register all 1s, shadow prescale=0, shadow N=1, capture count=0.
- Shadow load: on every clock with samp_en=1 and edge_cnt==0, latch prescale and vote_mode into shadow registers. All window arithmetic uses the shadow values, so mid-bit changes to prescale or vote_mode take effect from the next bit.
- Effective vote count: c = shadow_prescale>>1. Requested N comes from vote_mode, capped at MAX_VOTES. If c < N-1, N drops to the largest odd value ≤ c+1 (prescale 4 → c=2 → N≤3; prescale 2 or 3 → N=1; prescale 0/1 → N=1 at c=0).
- Window: edges c-N+1 .. c.
  - Edges c-N+1 .. c-1: shift rx_in into the vote register and increment the capture count.
  - Edge c: live rx_in is the final vote.
- Decision (registered at edge c):
  - sampled_bit = 1 iff popcount(N votes) ≥ (N+1)/2.
  - noise_flag = votes not all equal.
  - sample_valid = 1 for exactly that one cycle.
  - Then clear the vote register to 1s and the capture count to 0.
  - Latency: sampled_bit, sample_valid and noise_flag are visible the cycle after edge_cnt==c.
- Incomplete window: if the capture count at edge c is not N-1 (edge_cnt skipped or jumped), still decide. Missing votes count as 1 (idle). noise_flag is forced to 1.
- Outside the window: sample_valid=0; sampled_bit and noise_flag hold their values.
- samp_en=0: synchronous clear next cycle of vote register and capture count; sampled_bit=1; sample_valid=0; noise_flag=0. Applies mid-window too.
- samp_en rising on an edge_cnt inside the window: partial window; handled by the incomplete-window rule.
- edge_cnt ≥ prescale: ignored, no capture.
- Arithmetic: c-N+1 computed at CNT_W+1 bits signed. A negative lower bound cannot occur after the N reduction. popcount is 3 bits.
- rst asserted mid-window: immediate return to reset values; no stale votes survive.

Decomposition:
- Package uart_rx_pkg:
  - vote_mode encodings VOTE_1/VOTE_3/VOTE_5.
  - MAX_VOTES default.
  - Function eff_votes(prescale, mode) returning the reduced N.
- Sub-module rx_majority_vote: combinational; inputs votes[MAX_VOTES-1:0] and n; outputs maj and unanimous. Reused by the start-bit check.

Test Plan:
- prescale=8, mode=01, rx_in=1,0,1 at edges 2,3,4 → sampled_bit=1, noise_flag=1, sample_valid high 1 cycle after edge 4.
- prescale=16, mode=10, rx_in=0 on edges 4..8 except edge 6=1 → sampled_bit=0, noise_flag=1. Repeat all 0 → noise_flag=0.
- prescale=4, mode=10 → N reduces to 3, samples at edges 0,1,2. prescale=2 → N=1 at edge 1, noise_flag=0.
- samp_en drops at edge 3 of prescale 8 → no sample_valid, sampled_bit=1 next cycle. A partial window after re-enable at edge 3 → noise_flag=1.
- Change vote_mode 01→00 at edge 3 → current bit still uses 3 votes; next bit uses 1 vote at edge 4.
- rst pulsed at edge 3 → all outputs at reset values asynchronously. Next complete bit of all 0s yields sampled_bit=0, noise_flag=0.
